// File: rtl/craft_pipe_pkg.sv
// Shared types and constants for the ray pipeline: descriptor layout and default
// issue-FIFO depth.
package craft_pipe_pkg;

    localparam int RAY_DESC_W     = 192;
    localparam int RAY_FIFO_DEPTH = 4;

    // Origin and direction are three 24-bit fixed-point components each.
    typedef struct packed {
        logic [71:0] origin;
        logic [71:0] dir;
        logic [47:0] id;
    } ray_desc_t;

    function automatic logic [47:0] ray_desc_id(input ray_desc_t desc);
        return desc.id;
    endfunction

endpackage

// File: rtl/ray_fifo_mem.sv
// Descriptor storage for the issue FIFO: DEPTH x DATA_W registers, one write
// port, one asynchronous read port, no reset.
module ray_fifo_mem #(
    parameter int  DATA_W = 192,
    parameter int  DEPTH  = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/ray_issue_fifo.sv
// First-word-fall-through FIFO feeding a latency-counter-gated pipeline stage.
// Optional RAY_ISSUE_BYPASS_EN passes a descriptor straight through when empty.
module ray_issue_fifo
    import craft_pipe_pkg::*;
#(
    parameter int  DATA_W = RAY_DESC_W,
    parameter int  DEPTH  = RAY_FIFO_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic [ADDR_W:0]   level
);

    logic [ADDR_W:0]   wr_ptr;
    logic [ADDR_W:0]   rd_ptr;
    logic              empty;
    logic              full;
    logic              push;
    logic              pop;
    logic              bypass_take;
    logic [DATA_W-1:0] rd_data;

    // Pointers carry one extra wrap bit so full and empty are distinguishable.
    assign empty    = (wr_ptr == rd_ptr);
    assign full     = (wr_ptr[ADDR_W] != rd_ptr[ADDR_W]) &&
                      (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign level    = wr_ptr - rd_ptr;
    assign in_ready = ~full;

`ifdef RAY_ISSUE_BYPASS_EN
    assign bypass_take = empty & in_valid & out_ready;
    assign out_valid   = ~empty | in_valid;
    assign out_data    = !empty  ? rd_data :
                         in_valid ? in_data : '0;
`else
    assign bypass_take = 1'b0;
    assign out_valid   = ~empty;
    assign out_data    = empty ? '0 : rd_data;
`endif

    assign push = in_valid & in_ready & ~bypass_take;
    assign pop  = ~empty & out_ready;

    ray_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .wr_en   (push & ~flush),
        .wr_addr (wr_ptr[ADDR_W-1:0]),
        .wr_data (in_data),
        .rd_addr (rd_ptr[ADDR_W-1:0]),
        .rd_data (rd_data)
    );

    // Flush wins over any push or pop landing on the same edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ray_issue_fifo.sv
// Scoreboard bench for ray_issue_fifo: randomized and directed stimulus checked
// against a queue model of FIFO contents; a negedge monitor checks issue order.
module tb_ray_issue_fifo;
    import craft_pipe_pkg::*;

    localparam int DATA_W = RAY_DESC_W;
    localparam int DEPTH  = RAY_FIFO_DEPTH;
    localparam int ADDR_W = $clog2(DEPTH);

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              flush = 1'b0;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DATA_W-1:0] in_data = '0;
    logic              out_valid;
    logic              out_ready = 1'b0;
    logic [DATA_W-1:0] out_data;
    logic [ADDR_W:0]   level;

    int total = 0;
    int bad = 0;
    int unsigned serial = 0;
    logic [DATA_W-1:0] cur_desc;
    logic [DATA_W-1:0] exp_q [$];

`ifdef RAY_ISSUE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    ray_issue_fifo dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .level     (level)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [DATA_W-1:0] act,
                               input logic [DATA_W-1:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("[TB] FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [DATA_W-1:0] make_desc(input int unsigned id);
        ray_desc_t   d;
        logic [95:0] r;
        r        = {$urandom, $urandom, $urandom};
        d.origin = r[71:0];
        r        = {$urandom, $urandom, $urandom};
        d.dir    = r[71:0];
        d.id     = {16'h0, id};
        return d;
    endfunction

    // One clock of stimulus; outputs are compared against the model before it updates.
    task automatic applyStimulus(input logic iv, input logic ordy, input logic fl);
        int                sz;
        logic              exp_ov;
        logic [DATA_W-1:0] exp_od;
        logic              accepted;
        @(posedge clk);
        #1;
        in_valid  = iv;
        out_ready = ordy;
        flush     = fl;
        in_data   = cur_desc;
        #1;
        sz     = exp_q.size();
        exp_ov = (sz > 0) || (BYPASS && iv);
        exp_od = (sz > 0) ? exp_q[0] : ((BYPASS && iv) ? cur_desc : '0);
        checkOutput("level", DATA_W'(level), DATA_W'(sz));
        checkOutput("in_ready", DATA_W'(in_ready), DATA_W'(sz < DEPTH));
        checkOutput("out_valid", DATA_W'(out_valid), DATA_W'(exp_ov));
        checkOutput("out_data", out_data, exp_od);
        accepted = iv && !fl && (sz < DEPTH);
        if (fl) begin
            exp_q.delete();
        end else if (accepted) begin
            exp_q.push_back(cur_desc);
        end
        if (accepted || (fl && iv)) begin
            serial++;
            cur_desc = make_desc(serial);
        end
    endtask

    // Every issued descriptor must be the oldest one still expected.
    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL unexpected_issue actual=%0h required=none", out_data);
            end else begin
                checkOutput("issue_order", out_data, exp_q.pop_front());
            end
        end
    end

    initial begin
        int accepted_before;
        cur_desc = make_desc(serial);
        #2;
        checkOutput("reset_level", DATA_W'(level), '0);
        checkOutput("reset_in_ready", DATA_W'(in_ready), DATA_W'(1));
        checkOutput("reset_out_valid", DATA_W'(out_valid), '0);
        checkOutput("reset_out_data", out_data, '0);
        @(negedge clk);
        rst_n = 1'b1;

        // Zero-latency bypass check (or one-cycle latency without it).
        serial   = 32'h2A;
        cur_desc = make_desc(serial);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Burst of 10 against a sink ready one cycle in seven.
        accepted_before = int'(serial);
        for (int cyc = 0; cyc < 90; cyc++) begin
            if (int'(serial) - accepted_before >= 10 && exp_q.size() == 0) break;
            applyStimulus(int'(serial) - accepted_before < 10, (cyc % 7) == 6, 1'b0);
        end
        checkOutput("burst_count", DATA_W'(int'(serial) - accepted_before), DATA_W'(10));
        checkOutput("burst_drained", DATA_W'(exp_q.size()), '0);

        // Full with a simultaneous pop, then drain.
        for (int i = 0; i < 6; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Push and pop together at level 2.
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Flush at level 3 with a concurrent push.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b1, 1'b0);

        // Asynchronous reset mid-burst at level 3.
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        rst_n     = 1'b0;
        #1;
        checkOutput("midreset_level", DATA_W'(level), '0);
        checkOutput("midreset_in_ready", DATA_W'(in_ready), DATA_W'(1));
        checkOutput("midreset_out_valid", DATA_W'(out_valid), '0);
        checkOutput("midreset_out_data", out_data, '0);
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);

        // Randomized traffic with occasional flushes.
        for (int i = 0; i < 400; i++) begin
            logic iv;
            logic ordy;
            logic fl;
            iv   = ($urandom_range(0, 3) != 0);
            ordy = ($urandom_range(0, 2) == 0);
            fl   = ($urandom_range(0, 49) == 0);
            if (fl) ordy = 1'b0;
            applyStimulus(iv, ordy, fl);
        end
        for (int i = 0; i < DEPTH + 2; i++) applyStimulus(1'b0, 1'b1, 1'b0);
        checkOutput("final_drained", DATA_W'(exp_q.size()), '0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/ray_issue_fifo.md
Name: ray_issue_fifo

Overview:
Small FIFO that buffers ray descriptors from the ray generator and issues them one at a time to a fixed-latency pipeline stage (e.g. ray/box intersection). That stage's input ready comes from a ready/valid latency counter, so ready pulses only once per stage latency. The FIFO absorbs upstream bursts so the generator is not stalled for a full stage latency per ray. It sits directly upstream of the counter-gated stage.

Parameters:
DATA_W, 192, ray descriptor width in bits (origin + direction + id).
DEPTH, 4, number of entries; power of two, at least 2.
ADDR_W, $clog2(DEPTH), pointer index width; derived, not overridden.

Ports:
clk  input  1  clock; all state on rising edge.
rst_n  input  1  asynchronous active-low reset.
flush  input  1  synchronous clear of all entries.
in_valid  input  1  upstream descriptor valid.
in_ready  output  1  FIFO can accept; transfer when in_valid & in_ready.
in_data  input  DATA_W  upstream descriptor.
out_valid  output  1  descriptor available to the stage.
out_ready  input  1  stage ready (latency-counter output); transfer when out_valid & out_ready.
out_data  output  DATA_W  descriptor at head of FIFO.
level  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (rst_n low, async): wr_ptr = rd_ptr = 0; level = 0, in_ready = 1, out_valid = 0, out_data = 0. Storage array is not reset.
- Pointers are ADDR_W+1 bits; they wrap modulo 2*DEPTH. empty = (wr_ptr == rd_ptr); full = index bits equal and MSBs differ. level = wr_ptr - rd_ptr (modulo 2^(ADDR_W+1)).
- in_ready = ~full, derived from registered state only; no combinational path from out_ready.
- out_valid = ~empty, derived from registered state only (no bypass build); out_valid never depends on out_ready.
- out_data = mem[rd_ptr index], first-word-fall-through; it is stable while out_valid & ~out_ready.
- push = in_valid & in_ready: write mem[wr_ptr], wr_ptr += 1. pop = out_valid & out_ready: rd_ptr += 1.
- Write latency: a descriptor pushed into an empty FIFO at cycle N is presented on out_valid at N+1.
- Simultaneous push and pop with 0 < level < DEPTH: both occur; level unchanged.
- Full: in_ready = 0; a push is refused even if a pop happens in the same cycle (in_ready reflects the next cycle).
- Empty: pop impossible; out_ready is ignored.
- The stage's ready may be high for a single cycle only. A descriptor is never lost or duplicated regardless of the out_ready pattern.
- flush = 1: at the next edge both pointers reset to 0. Flush has priority over push and pop in the same cycle; any concurrent push is discarded. in_ready is not forced low during flush.
- Reset mid-operation: all contents are dropped; the state after release matches post-reset.

Optional Feature:
RAY_ISSUE_BYPASS_EN
- Defined: when empty & in_valid, out_valid = 1 and out_data = in_data combinationally. If out_ready is also high, the descriptor passes through with no write and no pointer change (zero latency). If out_ready is low, a normal push occurs.
- Undefined: no bypass; minimum in-to-out latency is 1 cycle and there is no combinational path from inputs to out_valid.

Decomposition:
- Shared package craft_pipe_pkg holds RAY_DESC_W (192), a ray_desc_t packed struct (origin, dir, id), and the default FIFO depth constant.
- One sub-module, ray_fifo_mem: a DEPTH x DATA_W register array with one write port and one async read port, no reset. Pointer and flag logic stays in ray_issue_fifo.

Test Plan:
- Reset: assert rst_n low mid-burst with level = 3 -> out_valid = 0, in_ready = 1, level = 0 immediately; first push after release appears at out_data the next cycle.
- Burst vs counter-gated sink: DEPTH = 4, 10 back-to-back pushes (ids 0..9); out_ready high for 1 cycle every 7 -> in_ready drops after the 4th accepted push; ids exit in order 0..9 with no loss or duplicates.
- Full with simultaneous pop: level = 4, in_valid = 1, out_ready = 1 -> pop occurs, push refused; level = 3 and in_ready = 1 next cycle.
- Simultaneous push/pop at level = 2: level stays 2 and the head advances by exactly one id.
- Flush: level = 3 with concurrent in_valid = 1 and flush = 1 -> level = 0 and out_valid = 0 next cycle; the pushed id does not appear later.
- With RAY_ISSUE_BYPASS_EN: empty, in_valid = 1 and out_ready = 1 with id 0x2A -> out_data = 0x2A in the same cycle and level stays 0. Without the macro -> out_valid = 0 that cycle and 0x2A is issued the next cycle.
